// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter unit.
//   Default*   : default parameter values for pc_unit and return_stack
//   pc_sel_e   : next-PC source selected each cycle
package pc_pkg;

  localparam int unsigned DefaultWidth       = 16;
  localparam int unsigned DefaultResetVector = 0;
  localparam int unsigned DefaultRasDepth    = 4;
  localparam int unsigned DefaultHist        = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack.
//   clock, reset  : clock and asynchronous active-low reset
//   push, pop     : push push_data / discard top entry (never both at once)
//   push_data     : address to push
//   top           : most recently pushed entry (meaningless while empty)
//   full, empty   : occupancy flags
// A push while full overwrites the oldest entry; a pop while empty is ignored.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultRasDepth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  ptr_q;    // next free slot; equals the oldest slot when full
  logic [PtrW:0]    count_q;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign top   = mem[ptr_q - 1'b1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + 1'b1;
      if (!full) count_q <= count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q   <= ptr_q - 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; entries are unreachable while count_q is zero.
  always_ff @(posedge clock) begin
    if (reset && push) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with return-address stack and PC history.
//   clock, reset          : clock and asynchronous active-low reset
//   ce                    : sequential advance
//   branchFlag/callFlag/retFlag, dr : redirects and their target
//   pc, pcPlusOne         : current PC (registered) and pc+1 (combinational)
//   pcHist, histValid     : delayed PCs, slice k is stage k+1, with valid bits
//   rasUnderflow/rasOverflow : one-cycle pulses after a bad pop / full push
// Priority: ret > call > branch > ce > hold.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DefaultResetVector),
  parameter int unsigned RAS_DEPTH = DefaultRasDepth,
  parameter int unsigned HIST = DefaultHist
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  branchFlag,
  input  logic                  callFlag,
  input  logic                  retFlag,
  input  logic [WIDTH-1:0]      dr,
  output logic [WIDTH-1:0]      pc,
  output logic [WIDTH-1:0]      pcPlusOne,
  output logic [HIST*WIDTH-1:0] pcHist,
  output logic [HIST-1:0]       histValid,
  output logic                  rasUnderflow,
  output logic                  rasOverflow
);

  pc_sel_e sel;
  logic [WIDTH-1:0] pc_q, pc_d, ras_top;
  logic ras_push, ras_pop, ras_full, ras_empty;
  logic [HIST-1:0][WIDTH-1:0] hist_q;
  logic [HIST-1:0] valid_q;
  logic underflow_q, overflow_q;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pcPlusOne),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pcPlusOne = pc_q + WIDTH'(1);

  always_comb begin
    sel = SEL_HOLD;
    if (retFlag)         sel = SEL_RET;
    else if (callFlag)   sel = SEL_CALL;
    else if (branchFlag) sel = SEL_BR;
    else if (ce)         sel = SEL_INC;
  end

  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    unique case (sel)
      SEL_INC:  pc_d = pcPlusOne;
      SEL_BR:   pc_d = dr;
      SEL_CALL: begin
        pc_d     = dr;
        ras_push = 1'b1;
      end
      SEL_RET: begin
        // An empty stack has no return address, so fall back to dr.
        ras_pop = !ras_empty;
        pc_d    = ras_empty ? dr : ras_top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_VECTOR;
      hist_q      <= '0;
      valid_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      underflow_q <= (sel == SEL_RET) && ras_empty;
      overflow_q  <= ras_push && ras_full;
      if (sel != SEL_HOLD) begin
        hist_q[0]  <= pc_q;
        valid_q[0] <= 1'b1;
        for (int k = 1; k < HIST; k++) begin
          hist_q[k]  <= hist_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end
  end

  assign pc           = pc_q;
  assign pcHist       = hist_q;
  assign histValid    = valid_q;
  assign rasUnderflow = underflow_q;
  assign rasOverflow  = overflow_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address stack entries, power of two, at least 2.
REQ-004 SHALL have parameter HIST, default 4: PC history stages, at least 1.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ce, input, 1 bit: advance enable (sequential increment).
REQ-008 SHALL have port branchFlag, input, 1 bit: jump to dr.
REQ-009 SHALL have port callFlag, input, 1 bit: jump to dr and push pcPlusOne.
REQ-010 SHALL have port retFlag, input, 1 bit: pop the stack into pc.
REQ-011 SHALL have port dr, input, WIDTH bits: branch/call target.
REQ-012 SHALL have port pc, output, WIDTH bits: current PC, registered.
REQ-013 SHALL have port pcPlusOne, output, WIDTH bits: pc+1, combinational, modulo 2^WIDTH.
REQ-014 SHALL have port pcHist, output, HIST*WIDTH bits: delayed PCs; slice k (bits k*WIDTH +: WIDTH) is stage k+1.
REQ-015 SHALL have port histValid, output, HIST bits: valid flag per history stage.
REQ-016 SHALL have port rasUnderflow, output, 1 bit: one-cycle pulse on a pop from an empty stack.
REQ-017 SHALL have port rasOverflow, output, 1 bit: one-cycle pulse on a push to a full stack.

Function
REQ-018 SHALL resolve the next PC each cycle by priority: retFlag > callFlag > branchFlag > ce > hold.
REQ-019 ret with stack non-empty: pc <= top entry; stack count decrements.
REQ-020 ret with stack empty: pc <= dr; count stays 0; rasUnderflow = 1 for one cycle.
REQ-021 call: pc <= dr; pcPlusOne is pushed; count increments, saturating at RAS_DEPTH.
REQ-022 call with stack full: push overwrites the oldest entry (circular); count stays RAS_DEPTH; rasOverflow = 1 for one cycle.
REQ-023 branch: pc <= dr; stack unchanged.
REQ-024 ce alone: pc <= pc+1, wrapping from 2^WIDTH-1 to 0; no flag raised.
REQ-025 Redirects (ret, call, branch) SHALL take effect regardless of ce.
REQ-026 A lower-priority flag asserted together with a higher-priority one SHALL have no effect; e.g. call+ret pops only, with no push.
REQ-027 History advances when advance = ce | ret | call | branch: stage 1 <= pc with valid 1; stage k <= stage k-1 including its valid bit.
REQ-028 When advance = 0, history and valid bits SHALL hold.
REQ-029 Each pulse output is registered and SHALL be high exactly in the cycle after the triggering edge.

Reset
REQ-030 While reset = 0, immediately and asynchronously: pc = RESET_VECTOR; all pcHist stages = 0; histValid = 0; stack count = 0; rasUnderflow = 0; rasOverflow = 0.
REQ-031 Stack entry contents need not be reset; they SHALL be unobservable while count = 0.
REQ-032 Reset asserted mid-operation SHALL discard any in-progress push or pop; the first edge after release SHALL act on the flags as normal.

Structure
REQ-033 Package pc_pkg SHALL hold the default WIDTH, RESET_VECTOR, RAS_DEPTH and HIST constants and the next-PC select enum {SEL_HOLD, SEL_INC, SEL_BR, SEL_CALL, SEL_RET}.
REQ-034 Sub-module return_stack SHALL implement the circular stack with push, pop, top, count, full, empty; pc_unit SHALL contain only select logic, pc register, history and flags.

Verification (WIDTH=16, RAS_DEPTH=4, HIST=4)
REQ-035 Release reset, ce=1 for 3 cycles -> pc 0,1,2,3; pcHist stage 1 = 2 and histValid = 0111 after the 3rd edge.
REQ-036 pc=0x0010, callFlag=1, dr=0x0100; then ce; then retFlag -> pc 0x0100, 0x0101, 0x0011; count 0,1,0.
REQ-037 5 calls from pc 0x0A, 0x14, 0x1E, 0x28, 0x32, all with dr=0x0A*k, then 5 rets -> rets yield 0x33, 0x29, 0x1F, 0x15, then underflow with pc = dr; one rasOverflow pulse after the 5th call and one rasUnderflow pulse on the 5th ret.
REQ-038 pc=0xFFFF, ce=1 -> pc 0x0000, pcPlusOne 0x0001, no flag raised.
REQ-039 ret+call+branch together with stack top 0x0042 -> pc 0x0042, count decrements, no push.
REQ-040 Reset pulsed low mid-cycle during callFlag -> pc = 0 immediately, count 0, histValid 0000, no rasOverflow pulse.
